universal_gate_sequencer: RTL and testbench

- Bit-serial controller that computes any 2-input logic function over WIDTH-bit operands using one shared 1-bit NAND/NOR primitive.
- Sequences micro-steps per bit: XOR takes 4 NAND evaluations, AND takes 2, and so on.
- Sits between a requester with a valid/ready command interface and the single universal gate instance.
- Demonstrates NAND/NOR universality in hardware, trading latency for a minimal gate count.

---
 rtl/universal_gate_sequencer_pkg.sv | 44 ++++
 rtl/universal_gate_sequencer_if.sv | 25 ++
 rtl/universal_gate.sv | 10 +
 rtl/universal_gate_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_universal_gate_sequencer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/universal_gate_sequencer_pkg.sv
// Shared opcodes, state encoding and per-opcode micro-step counts for the
// bit-serial universal gate sequencer.
package universal_gate_sequencer_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned STEP_W = 3;

  localparam logic [OP_W-1:0] OP_NAND = 3'd0;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Destination of the primitive's output on the current micro-step.
  typedef enum logic [2:0] {
    WR_NONE = 3'd0,
    WR_T1   = 3'd1,
    WR_T2   = 3'd2,
    WR_T3   = 3'd3,
    WR_RES  = 3'd4
  } wr_sel_t;

  function automatic logic [STEP_W-1:0] step_count(input logic [OP_W-1:0] op);
    logic [STEP_W-1:0] s;
    case (op)
      OP_NAND, OP_NOR, OP_NOT: s = 3'd1;
      OP_AND, OP_OR:           s = 3'd2;
      OP_XOR:                  s = 3'd4;
      OP_XNOR:                 s = 3'd5;
      default:                 s = 3'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/universal_gate_sequencer_if.sv
// Command (valid/ready) and result (valid/ready) channels between the
// requester and the sequencer.
interface universal_gate_sequencer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/universal_gate.sv
// Single 1-bit universal primitive exposing both NAND and NOR of its inputs.
module universal_gate (
  input  logic a,
  input  logic b,
  output logic NAND_out,
  output logic NOR_out
);
  assign NAND_out = ~(a & b);
  assign NOR_out  = ~(a | b);
endmodule

// File: rtl/universal_gate_sequencer.sv
// Bit-serial evaluator of 2-input logic functions built from repeated
// evaluations of one shared NAND/NOR primitive, LSB first.
module universal_gate_sequencer
  import universal_gate_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  universal_gate_sequencer_if.slave   bus,
  output logic [CNT_W-1:0]            gate_evals
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t              state, next_state;
  logic [OP_W-1:0]     op_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [IDX_W-1:0]    bit_idx, bit_idx_d;
  logic [STEP_W-1:0]   step, step_d;
  logic                t1, t2, t3, t1_d, t2_d, t3_d;
  logic [WIDTH-1:0]    result, result_d;
  logic                err, err_d;
  logic                out_valid, out_valid_d;
  logic                in_ready, in_ready_d;
  logic [CNT_W-1:0]    gate_evals_d;

  logic                x, y;
  logic                ga, gb, use_nor;
  wr_sel_t             wr_sel;
  logic                nand_o, nor_o, gate_o;
  logic                accept, release_hs, last_step, last_bit;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.err       = err;

  assign accept     = (state == IDLE) && bus.in_valid && in_ready;
  assign release_hs = (state == DONE) && out_valid && bus.out_ready;
  assign last_step  = (step == (step_count(op_q) - STEP_W'(1)));
  assign last_bit   = (bit_idx == LAST_IDX);

  assign x = a_q[bit_idx];
  assign y = b_q[bit_idx];

  universal_gate u_gate (
    .a        (ga),
    .b        (gb),
    .NAND_out (nand_o),
    .NOR_out  (nor_o)
  );

  assign gate_o = use_nor ? nor_o : nand_o;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (bus.op == OP_RSVD) ? DONE : EXEC;
      EXEC: if (last_step && last_bit) next_state = DONE;
      DONE: if (release_hs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Primitive input muxing and destination select for the current micro-step.
  always_comb begin
    ga      = x;
    gb      = y;
    use_nor = 1'b0;
    wr_sel  = WR_NONE;
    if (state == EXEC) begin
      case (op_q)
        OP_NAND: wr_sel = WR_RES;
        OP_NOR: begin
          use_nor = 1'b1;
          wr_sel  = WR_RES;
        end
        OP_AND, OP_OR: begin
          use_nor = (op_q == OP_OR);
          if (step == 3'd0) begin
            wr_sel = WR_T1;
          end else begin
            ga     = t1;
            gb     = t1;
            wr_sel = WR_RES;
          end
        end
        OP_NOT: begin
          gb     = x;
          wr_sel = WR_RES;
        end
        OP_XOR, OP_XNOR: begin
          case (step)
            3'd0: wr_sel = WR_T1;
            3'd1: begin
              gb     = t1;
              wr_sel = WR_T2;
            end
            3'd2: begin
              ga     = y;
              gb     = t1;
              wr_sel = WR_T3;
            end
            3'd3: begin
              ga     = t2;
              gb     = t3;
              // XNOR keeps the XOR bit in t1 for its final inversion.
              wr_sel = (op_q == OP_XOR) ? WR_RES : WR_T1;
            end
            default: begin
              ga     = t1;
              gb     = t1;
              wr_sel = WR_RES;
            end
          endcase
        end
        default: wr_sel = WR_NONE;
      endcase
    end
  end

  // Datapath next values.
  always_comb begin
    bit_idx_d    = bit_idx;
    step_d       = step;
    t1_d         = t1;
    t2_d         = t2;
    t3_d         = t3;
    result_d     = result;
    err_d        = err;
    gate_evals_d = gate_evals;
    in_ready_d   = (next_state == IDLE);
    // A reserved op reaches DONE from IDLE and raises out_valid one edge later.
    out_valid_d  = (next_state == DONE) && (state != IDLE);

    if (accept) begin
      bit_idx_d = '0;
      step_d    = '0;
      result_d  = '0;
      err_d     = (bus.op == OP_RSVD);
    end

    if (state == EXEC) begin
      if (gate_evals != {CNT_W{1'b1}}) gate_evals_d = gate_evals + CNT_W'(1);
      case (wr_sel)
        WR_T1:   t1_d = gate_o;
        WR_T2:   t2_d = gate_o;
        WR_T3:   t3_d = gate_o;
        WR_RES:  result_d[bit_idx] = gate_o;
        default: ;
      endcase
      if (last_step) begin
        step_d = '0;
        if (!last_bit) bit_idx_d = bit_idx + IDX_W'(1);
      end else begin
        step_d = step + STEP_W'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      bit_idx    <= '0;
      step       <= '0;
      t1         <= 1'b0;
      t2         <= 1'b0;
      t3         <= 1'b0;
      result     <= '0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      gate_evals <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      bit_idx    <= bit_idx_d;
      step       <= step_d;
      t1         <= t1_d;
      t2         <= t2_d;
      t3         <= t3_d;
      result     <= result_d;
      err        <= err_d;
      out_valid  <= out_valid_d;
      in_ready   <= in_ready_d;
      gate_evals <= gate_evals_d;
    end
  end

endmodule

// File: tb/tb_universal_gate_sequencer.sv
// Randomized and directed check of universal_gate_sequencer against a
// truth-level reference model.
module tb_universal_gate_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] gate_evals;

  int errors = 0;
  int checks = 0;
  int exp_evals = 0;

  universal_gate_sequencer_if #(.WIDTH(WIDTH)) bus ();

  universal_gate_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .gate_evals (gate_evals)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return ~(a & b);
      3'd1: return ~(a | b);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_steps(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd6: return 1;
      3'd2, 3'd3:       return 2;
      3'd4:             return 4;
      3'd5:             return 5;
      default:          return 0;
    endcase
  endfunction

  // Issue one command, check latency/result/err/counter, hold backpressure
  // for 'hold' cycles with a competing request, then release.
  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int hold);
    int cyc;
    int exp_lat;
    logic [WIDTH-1:0] exp_res;
    logic [WIDTH-1:0] held;
    exp_res = ref_result(op, a, b);
    exp_lat = (op == 3'd7) ? 1 : WIDTH * ref_steps(op);

    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_before_cmd", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom_range(7, 0));
    bus.a  = WIDTH'($urandom);
    bus.b  = WIDTH'($urandom);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);

    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    exp_evals = exp_evals + WIDTH * ref_steps(op);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("result", 32'(bus.result), 32'(exp_res));
    check("err", 32'(bus.err), 32'(op == 3'd7));
    check("gate_evals", 32'(gate_evals), 32'(exp_evals));
    check("in_ready_done", 32'(bus.in_ready), 32'd0);

    held = bus.result;
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.op = 3'($urandom_range(6, 0));
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result_stable", 32'(bus.result), 32'(held));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("gate_evals_idle", 32'(gate_evals), 32'(exp_evals));
  endtask

  initial begin
    int cyc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a  = '0;
    bus.b  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_gate_evals", 32'(gate_evals), 32'd0);
    rst_n = 1'b1;

    run_cmd(3'd4, 4'b1100, 4'b1010, 0);
    run_cmd(3'd2, 4'b1101, 4'b0111, 1);
    run_cmd(3'd3, 4'b1101, 4'b0111, 0);
    run_cmd(3'd5, 4'b0000, 4'b1111, 2);
    run_cmd(3'd6, 4'b1001, 4'b0000, 0);
    run_cmd(3'd7, 4'b1011, 4'b0110, 1);
    run_cmd(3'd1, 4'b0101, 4'b0011, 10);

    // Abort an XOR partway through with a one-edge reset.
    bus.in_valid = 1'b1;
    bus.op = 3'd4;
    bus.a  = 4'b0110;
    bus.b  = 4'b0011;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_evals = 0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_gate_evals", 32'(gate_evals), 32'd0);
    cyc = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.out_valid) cyc++;
    end
    check("abort_no_output", 32'(cyc), 32'd0);

    run_cmd(3'd0, 4'b1111, 4'b0101, 0);

    for (int n = 0; n < 40; n++) begin
      run_cmd(3'($urandom_range(7, 0)), WIDTH'($urandom), WIDTH'($urandom),
              int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
